// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and timeout-counter sizing for the APB master bridge
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Counter width for the default 255-cycle wait-state limit
    localparam int APB_TO_CNT_W = $clog2(255 + 1);

    // Counter width able to hold the value 'limit' itself
    function automatic int apb_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating ACCESS wait-state counter flagging when LIMIT waits have elapsed
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int W     = APB_TO_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [W-1:0] r_cnt;

    assign o_expired = (r_cnt == W'(LIMIT));

    // Clear on SETUP, count each stalled ACCESS cycle, saturate at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: req/gnt/rvalid port to APB3 master; define APB_MASTER_TIMEOUT_EN for the ACCESS wait-state timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be within 1..65535");
    end

    apb_state_e                r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic                      r_err;
    logic                      w_abort;

    assign gnt_o     = (r_state == IDLE) && req_i;
    assign paddr_o   = r_paddr;
    assign pwdata_o  = r_pwdata;
    assign pwrite_o  = r_pwrite;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_expired;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (apb_cnt_w(TIMEOUT_CYCLES))
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == SETUP),
        .i_en      ((r_state == ACCESS) && !pready_i),
        .o_expired (w_expired)
    );

    // Limit reached with the slave still stalling: give up on this transfer
    assign w_abort = (r_state == ACCESS) && !pready_i && w_expired;
`else
    assign w_abort = 1'b0;
`endif

    // APB phase sequencer with registered bus signals and one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_paddr  <= addr_i;
                        r_pwdata <= wdata_i;
                        r_pwrite <= we_i;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i || w_abort) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_err     <= pready_i ? pslverr_i : 1'b1;
                        r_rdata   <= (pready_i && !r_pwrite) ? prdata_i : '0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge (timeout scenarios under APB_MASTER_TIMEOUT_EN)
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int          wait_n = 0;
    int          acc_cnt;
    logic [31:0] rd_data = '0;
    logic        slverr = 1'b0;

    logic [32:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .pwrite_o  (pwrite_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    always #5 clk = ~clk;

    // Slave model: raise pready after wait_n stalled ACCESS cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (psel_o && penable_o) acc_cnt <= pready_i ? 0 : acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign pready_i  = psel_o && penable_o && (acc_cnt >= wait_n);
    assign prdata_i  = rd_data;
    assign pslverr_i = slverr;

    // Response monitor: every rvalid pulse must match the oldest expected response
    always @(negedge clk) begin
        if (rst_n && rvalid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid rdata=%h err=%b with no transfer outstanding", rdata_o, err_o);
            end else begin
                logic [32:0] exp;
                exp = sb.pop_front();
                if ({rdata_o, err_o} !== exp) begin
                    errors++;
                    $display("FAIL response got rdata=%h err=%b expected rdata=%h err=%b",
                             rdata_o, err_o, exp[32:1], exp[0]);
                end
            end
        end else if (rst_n && err_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL err_outside_rvalid got %b expected 0", err_o);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        smp();
        checks++;
        if ({psel_o, penable_o, pwrite_o, rvalid_o, err_o, gnt_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {psel_o, penable_o, pwrite_o, rvalid_o, err_o, gnt_o});
        end
        checks++;
        if ({paddr_o, pwdata_o, rdata_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h expected all 0", paddr_o, pwdata_o, rdata_o);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        wait_n = 0;
        cyc();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1A10_1004; wdata_i = 32'hDEAD_BEEF;
        smp();
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL write_gnt got %b expected 1", gnt_o);
        end
        sb.push_back({32'h0, 1'b0});
        cyc();
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        smp();
        checks++;
        if ({psel_o, penable_o, gnt_o} !== 3'b100 || paddr_o !== 32'h1A10_1004) begin
            errors++;
            $display("FAIL write_setup got psel/pen/gnt=%b paddr=%h expected 100 1a101004",
                     {psel_o, penable_o, gnt_o}, paddr_o);
        end
        cyc();
        smp();
        checks++;
        if ({psel_o, penable_o, pwrite_o, gnt_o} !== 4'b1110 || pwdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_access got psel/pen/pwrite/gnt=%b pwdata=%h expected 1110 deadbeef",
                     {psel_o, penable_o, pwrite_o, gnt_o}, pwdata_o);
        end
        cyc();
        smp();
        checks++;
        if ({rvalid_o, psel_o, penable_o} !== 3'b100 || paddr_o !== 32'h1A10_1004) begin
            errors++;
            $display("FAIL write_resp got rvalid/psel/pen=%b paddr=%h expected 100 1a101004",
                     {rvalid_o, psel_o, penable_o}, paddr_o);
        end
    endtask

    task automatic test_read_wait(input logic [31:0] addr, input int waits, input logic [31:0] data,
                                  input logic [32:0] exp_resp, input int exp_en);
        int en_cnt;
        bit stable;
        bit got;
        en_cnt = 0;
        stable = 1'b1;
        got = 1'b0;
        wait_n = waits;
        rd_data = data;
        slverr = 1'b0;
        cyc();
        req_i = 1'b1; we_i = 1'b0; addr_i = addr;
        smp();
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL read_gnt got %b expected 1", gnt_o);
        end
        sb.push_back(exp_resp);
        cyc();
        req_i = 1'b0; addr_i = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            smp();
            if (penable_o) en_cnt++;
            if (psel_o && paddr_o !== addr) stable = 1'b0;
            if (rvalid_o) got = 1'b1;
            else cyc();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL read_timeout got no rvalid expected one within 40 cycles");
        end
        checks++;
        if (en_cnt !== exp_en) begin
            errors++;
            $display("FAIL read_penable_cycles got %0d expected %0d", en_cnt, exp_en);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL read_addr_stable got changing paddr expected %h", addr);
        end
    endtask

    task automatic test_err_regrant();
        wait_n = 0;
        slverr = 1'b1;
        rd_data = 32'h0000_5A5A;
        cyc();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_2008;
        smp();
        sb.push_back({32'h0000_5A5A, 1'b1});
        cyc();
        req_i = 1'b0;
        smp();
        cyc();
        smp();
        cyc();
        slverr = 1'b0;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1A10_200C; wdata_i = 32'h0000_0001;
        smp();
        checks++;
        if ({rvalid_o, gnt_o} !== 2'b11) begin
            errors++;
            $display("FAIL err_regrant got rvalid/gnt=%b expected 11", {rvalid_o, gnt_o});
        end
        sb.push_back({32'h0, 1'b0});
        cyc();
        req_i = 1'b0;
        smp();
        cyc();
        smp();
        cyc();
        smp();
        checks++;
        if (rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL regrant_resp got rvalid=%b expected 1", rvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        int gcount;
        int rcount;
        int first;
        int last;
        gcount = 0;
        rcount = 0;
        first = -1;
        last = -1;
        wait_n = 0;
        rd_data = 32'hCAFE_0000;
        cyc();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A11_0000; wdata_i = 32'h1111_0000;
        for (int c = 0; c < 40 && rcount < 4; c++) begin
            smp();
            if (gnt_o) begin
                sb.push_back({we_i ? 32'h0 : rd_data, 1'b0});
                if (gcount == 0) first = c;
                gcount++;
            end
            if (rvalid_o) begin
                rcount++;
                last = c;
            end
            cyc();
            if (gcount == 4) req_i = 1'b0;
            we_i = gcount[0];
            addr_i = 32'h1A11_0000 + 32'(gcount * 4);
            wdata_i = 32'h1111_0000 + 32'(gcount);
        end
        req_i = 1'b0;
        checks++;
        if (gcount !== 4 || rcount !== 4) begin
            errors++;
            $display("FAIL b2b_counts got gnt=%0d rvalid=%0d expected 4 4", gcount, rcount);
        end
        checks++;
        if (last - first !== 12) begin
            errors++;
            $display("FAIL b2b_cycles got %0d expected 12", last - first);
        end
    endtask

    task automatic test_reset_mid();
        int rv;
        rv = 0;
        wait_n = 5;
        cyc();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_4000;
        smp();
        cyc();
        req_i = 1'b0;
        smp();
        cyc();
        smp();
        checks++;
        if (penable_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_access got penable=%b expected 1", penable_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_async got psel/pen=%b expected 00", {psel_o, penable_o});
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_n = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (rvalid_o) rv++;
        end
        checks++;
        if (rv !== 0) begin
            errors++;
            $display("FAIL rst_mid_rvalid got %0d pulses expected 0", rv);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait(32'h1A10_3000, 3, 32'h0000_00A5, {32'h0000_00A5, 1'b0}, 4);
        test_err_regrant();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
        test_read_wait(32'h1A10_5000, 1000, 32'hFFFF_FFFF, {32'h0, 1'b1}, 5);
        test_read_wait(32'h1A10_5004, 4, 32'h1234_5678, {32'h1234_5678, 1'b0}, 5);
`endif
        repeat (3) smp();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d outstanding expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple request/grant/rvalid port (core or debug side) into APB3 transfers on an APB_BUS Master-modport-compatible signal set.
- Sits upstream of the SoC peripheral address decoder/interconnect; drives a single psel; the downstream decoder fans out per peripheral window (0x1A10_0000–0x1A11_7FFF).
- Sequences SETUP/ACCESS phases, honours pready wait states, returns prdata/pslverr as a single-cycle response.

Parameters:
- APB_ADDR_WIDTH, 32, width of paddr / addr_i
- APB_DATA_WIDTH, 32, width of pwdata/prdata/wdata_i/rdata_o
- TIMEOUT_CYCLES, 255, ACCESS wait-state limit; used only with APB_MASTER_TIMEOUT_EN; legal range 1..65535

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  transfer request; held until gnt_o
- we_i  in  1  1 = write, 0 = read
- addr_i  in  APB_ADDR_WIDTH  byte address
- wdata_i  in  APB_DATA_WIDTH  write data
- gnt_o  out  1  request accepted this cycle (combinational)
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  1  transfer error, valid with rvalid_o
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- pwrite_o  out  1  APB direction
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready / wait-state
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset (async assert, sync-released by system): state=IDLE; paddr_o, pwdata_o, pwrite_o, psel_o, penable_o, rvalid_o, rdata_o, err_o all 0.
- FSM states IDLE, SETUP, ACCESS.
- IDLE: gnt_o = req_i. On grant: register addr_i, wdata_i, we_i into paddr_o, pwdata_o, pwrite_o; next state SETUP. gnt_o is 0 in SETUP/ACCESS.
- SETUP: psel_o=1, penable_o=0; next state ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1. pready_i=0 -> stay (wait state). pready_i=1 -> next IDLE; next cycle rvalid_o=1, err_o=pslverr_i, rdata_o = (read ? prdata_i : 0).
- paddr_o/pwdata_o/pwrite_o stable from SETUP through final ACCESS cycle; after completion they hold their value (no toggling in IDLE); psel_o/penable_o deassert in IDLE.
- Zero-wait latency: grant cycle N, SETUP N+1, ACCESS N+2, rvalid_o N+3. Max throughput one transfer per 3 cycles; the rvalid_o cycle may also grant the next request.
- rvalid_o, err_o: exactly one cycle; 0 otherwise. rdata_o holds last captured value between responses.
- pslverr_i and prdata_i sampled only in ACCESS with pready_i=1; ignored elsewhere.
- Reset mid-transfer: psel_o/penable_o drop immediately; no rvalid_o is issued for the aborted transfer.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined: counter clears on SETUP entry and increments each ACCESS cycle with pready_i=0. When count reaches TIMEOUT_CYCLES with pready_i still 0: transfer aborts to IDLE; next cycle rvalid_o=1, err_o=1, rdata_o=0. pready_i=1 on the limit cycle completes normally.
- Not defined: no counter; ACCESS waits indefinitely on pready_i.

Decomposition:
- apb_pkg: apb_state_e enum {IDLE, SETUP, ACCESS}; localparam APB_TO_CNT_W = $clog2(TIMEOUT_CYCLES+1).
- One sub-module apb_timeout_cnt (clear, enable, expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x1A10_1004, data 0xDEAD_BEEF, pready=1 -> psel at N+1, penable at N+2 with pwrite=1, rvalid N+3, err=0, rdata=0.
- Read 0x1A10_3000, 3 wait states, prdata=0x0000_00A5 -> penable held 4 cycles, addr stable, rvalid once with rdata=0xA5.
- Read with pslverr=1 on ready -> rvalid=1, err=1; next request granted in the same rvalid cycle.
- Back-to-back: req held high for 4 transfers -> gnt only in IDLE, 4 rvalid pulses, 12 cycles total.
- rst_n low during ACCESS -> psel/penable 0 asynchronously, no rvalid after release.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> abort after 4 wait cycles, rvalid=1, err=1, rdata=0.
